// File: rtl/operand_selector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : operand_selector                                        |
// | Picks operand matrix IDs A/B (switch entry or LFSR) and checks     |
// | their dimensions against the requested matrix operation.           |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module operand_selector #(
  parameter int         ID_W      = 4,
  parameter int         MAX_TRIES = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_select,
  input  logic            manual_mode,
  input  logic [2:0]      op_sel,
  input  logic [ID_W-1:0] id_sw,
  input  logic            key_confirm,
  input  logic [ID_W:0]   mat_count,
  output logic [ID_W-1:0] dim_id,
  input  logic [2:0]      dim_rows,
  input  logic [2:0]      dim_cols,
  output logic            select_done,
  output logic            select_error,
  output logic [ID_W-1:0] selected_a,
  output logic [ID_W-1:0] selected_b,
  output logic            busy,
  output logic [1:0]      phase
);

  localparam logic [2:0] c_OP_TRANSPOSE = 3'b000;
  localparam logic [2:0] c_OP_ADD       = 3'b001;
  localparam logic [2:0] c_OP_SCALAR    = 3'b010;
  localparam logic [2:0] c_OP_MATMUL    = 3'b011;
  localparam logic [2:0] c_OP_DET       = 3'b100;
  localparam logic [7:0] c_LFSR_TAPS    = 8'h71;  // x^6+x^5+x^4+1 below the x^8 term
  localparam logic [7:0] c_MAX_TRIES    = 8'(MAX_TRIES);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WAIT_A  = 4'd1,
    S_WAIT_B  = 4'd2,
    S_RAND    = 4'd3,
    S_FETCH_A = 4'd4,
    S_FETCH_B = 4'd5,
    S_CHECK   = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  state_t          w_start_state;
  logic [7:0]      r_lfsr;
  logic [7:0]      r_tries;
  logic            r_manual;
  logic [2:0]      r_op;
  logic [ID_W-1:0] r_a;
  logic [ID_W-1:0] r_b;
  logic [2:0]      r_ra;
  logic [2:0]      r_ca;
  logic [ID_W-1:0] r_sel_a;
  logic [ID_W-1:0] r_sel_b;
  logic [ID_W-1:0] r_dim_last;

  logic            w_unary;
  logic            w_id_bad;
  logic [ID_W-1:0] w_rand_a;
  logic [ID_W-1:0] w_rand_b;
  logic            w_rand_reject;
  logic [7:0]      w_tries_inc;
  logic            w_compat;

  assign w_unary       = (r_op == c_OP_TRANSPOSE) || (r_op == c_OP_SCALAR) || (r_op == c_OP_DET);
  assign w_id_bad      = ({1'b0, id_sw} >= mat_count);
  assign w_rand_a      = r_lfsr[ID_W-1:0];
  assign w_rand_b      = w_unary ? w_rand_a : r_lfsr[7:8-ID_W];
  assign w_rand_reject = ({1'b0, w_rand_a} >= mat_count) || ({1'b0, w_rand_b} >= mat_count);
  assign w_tries_inc   = r_tries + 8'd1;
  assign selected_a    = r_sel_a;
  assign selected_b    = r_sel_b;

  // B's dimensions are taken straight off the store bus during CHECK
  always_comb begin
    w_compat = 1'b1;
    case (r_op)
      c_OP_ADD:    w_compat = (r_ra == dim_rows) && (r_ca == dim_cols);
      c_OP_MATMUL: w_compat = (r_ca == dim_rows);
      c_OP_DET:    w_compat = (r_ra == r_ca);
      default:     w_compat = 1'b1;
    endcase
  end

  always_comb begin
    w_start_state = S_RAND;
    if ((mat_count == '0) || (op_sel > c_OP_DET)) begin
      w_start_state = S_ERR;
    end else if (manual_mode) begin
      w_start_state = S_WAIT_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b0;
    phase        = 2'd0;
    select_done  = 1'b0;
    select_error = 1'b0;
    dim_id       = r_dim_last;
    case (r_state)
      S_WAIT_A: begin
        busy  = 1'b1;
        phase = 2'd1;
        if (key_confirm) begin
          if (w_id_bad)     w_state_nxt = S_ERR;
          else if (w_unary) w_state_nxt = S_FETCH_A;
          else              w_state_nxt = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        busy  = 1'b1;
        phase = 2'd2;
        if (key_confirm) begin
          w_state_nxt = w_id_bad ? S_ERR : S_FETCH_A;
        end
      end
      S_RAND: begin
        busy  = 1'b1;
        phase = 2'd3;
        if (!w_rand_reject)                 w_state_nxt = S_FETCH_A;
        else if (w_tries_inc == c_MAX_TRIES) w_state_nxt = S_ERR;
      end
      S_FETCH_A: begin
        busy        = 1'b1;
        phase       = 2'd3;
        dim_id      = r_a;
        w_state_nxt = S_FETCH_B;
      end
      S_FETCH_B: begin
        busy        = 1'b1;
        phase       = 2'd3;
        dim_id      = r_b;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy  = 1'b1;
        phase = 2'd3;
        if (w_compat)                                w_state_nxt = S_DONE;
        else if (r_manual || (r_tries == c_MAX_TRIES)) w_state_nxt = S_ERR;
        else                                         w_state_nxt = S_RAND;
      end
      S_DONE:  select_done  = 1'b1;
      S_ERR:   select_error = 1'b1;
      default: w_state_nxt  = r_state;
    endcase
    if (start_select) begin
      w_state_nxt = w_start_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr     <= LFSR_SEED;
      r_dim_last <= '0;
    end else begin
      r_lfsr     <= {r_lfsr[6:0], 1'b0} ^ (r_lfsr[7] ? c_LFSR_TAPS : 8'h00);
      r_dim_last <= dim_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tries  <= '0;
      r_manual <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_ra     <= '0;
      r_ca     <= '0;
      r_sel_a  <= '0;
      r_sel_b  <= '0;
    end else if (start_select) begin
      r_tries  <= '0;
      r_manual <= manual_mode;
      r_op     <= op_sel;
      r_sel_a  <= '0;
      r_sel_b  <= '0;
    end else begin
      case (r_state)
        S_WAIT_A: begin
          // B mirrors A so unary ops need no second entry
          if (key_confirm) begin
            r_a <= id_sw;
            r_b <= id_sw;
          end
        end
        S_WAIT_B: begin
          if (key_confirm) r_b <= id_sw;
        end
        S_RAND: begin
          r_a     <= w_rand_a;
          r_b     <= w_rand_b;
          r_tries <= w_tries_inc;
        end
        S_FETCH_B: begin
          r_ra <= dim_rows;
          r_ca <= dim_cols;
        end
        S_CHECK: begin
          if (w_compat) begin
            r_sel_a <= r_a;
            r_sel_b <= r_b;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(select_done && select_error));
      assert (r_lfsr != 8'h00);
    end
  end
`endif

endmodule
`default_nettype wire
